// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, valid/ready handshake and flush.
// Define PIPE_STAGE_DATA_RESET_EN to reset/flush-clear the ctrl/data storage registers.
module pipe_stage_reg #(
  parameter int unsigned CW = 8,
  parameter int unsigned DW = 101
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctrl,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic          in_xfer, out_xfer;

  // Decoded from state only, so out_ready never reaches in_ready combinationally.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign occupancy = state_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = StEmpty;
`ifdef PIPE_STAGE_DATA_RESET_EN
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
`endif
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d     = StOne;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_xfer) begin
            state_d     = StFull;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_xfer) begin
            state_d     = StOne;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_STAGE_DATA_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    main_ctrl_q <= main_ctrl_d;
    main_data_q <= main_data_d;
    skid_ctrl_q <= skid_ctrl_d;
    skid_data_q <= skid_data_d;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg using immediate assertions.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 101;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int n_tests;
  int n_fail;

  pipe_stage_reg #(
    .CW(CW),
    .DW(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the handshake/status outputs together.
  task automatic chk_st(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(ov));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(ir));
    chk({tag, ".occupancy"}, 128'(occupancy), 128'(occ));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk_st("reset", 1'b0, 1'b1, 2'd0);
    chk("reset.out_ctrl", 128'(out_ctrl), 128'(0));
`ifdef PIPE_STAGE_DATA_RESET_EN
    chk("reset.out_data", 128'(out_data), 128'(0));
`endif
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk_st("post_reset", 1'b0, 1'b1, 2'd0);

    // Streaming: one entry per cycle, 1-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      cyc();
      chk_st($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
      chk($sformatf("stream%0d.data", i), 128'(out_data), 128'(i));
      chk($sformatf("stream%0d.ctrl", i), 128'(out_ctrl), 128'(8'hA5));
    end
    in_valid = 1'b0;
    cyc();
    chk_st("stream_drain", 1'b0, 1'b1, 2'd0);
    chk("stream_drain.ctrl", 128'(out_ctrl), 128'(0));

    // Backpressure: 10, 11 accepted, 12 held upstream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h3C;
    in_data   = DW'(10);
    cyc();
    chk_st("bp_a", 1'b1, 1'b1, 2'd1);
    chk("bp_a.data", 128'(out_data), 128'(10));
    in_data = DW'(11);
    cyc();
    chk_st("bp_b", 1'b1, 1'b0, 2'd2);
    chk("bp_b.data", 128'(out_data), 128'(10));
    in_data = DW'(12);
    cyc();
    chk_st("bp_c", 1'b1, 1'b0, 2'd2);
    chk("bp_c.data", 128'(out_data), 128'(10));
    chk("bp_c.ctrl", 128'(out_ctrl), 128'(8'h3C));
    out_ready = 1'b1;
    cyc();
    chk_st("bp_d", 1'b1, 1'b1, 2'd1);
    chk("bp_d.data", 128'(out_data), 128'(11));
    cyc();
    chk_st("bp_e", 1'b1, 1'b1, 2'd1);
    chk("bp_e.data", 128'(out_data), 128'(12));
    in_valid = 1'b0;
    cyc();
    chk_st("bp_drain", 1'b0, 1'b1, 2'd0);

    // Flush when FULL discards held entries and the incoming 20
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h5A;
    in_data   = DW'(21);
    cyc();
    in_data = DW'(22);
    cyc();
    chk_st("fl_full_pre", 1'b1, 1'b0, 2'd2);
    in_data = DW'(20);
    flush   = 1'b1;
    cyc();
    chk_st("fl_full", 1'b0, 1'b1, 2'd0);
    chk("fl_full.ctrl", 128'(out_ctrl), 128'(0));
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk_st("fl_full_after", 1'b0, 1'b1, 2'd0);

    // Back-to-back flush with in_valid held: stays EMPTY
    in_valid = 1'b1;
    in_data  = DW'(25);
    flush    = 1'b1;
    cyc();
    chk_st("fl_b2b_1", 1'b0, 1'b1, 2'd0);
    cyc();
    chk_st("fl_b2b_2", 1'b0, 1'b1, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Flush with simultaneous out-transfer: 30 delivered, then EMPTY
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'h81;
    in_data   = DW'(30);
    cyc();
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    chk("fl_xfer.delivered", 128'(out_valid & out_ready), 128'(1));
    chk("fl_xfer.data", 128'(out_data), 128'(30));
    cyc();
    chk_st("fl_xfer_after", 1'b0, 1'b1, 2'd0);
    flush = 1'b0;

    // Bubble masking: ctrl bits held in main must not leak
    in_valid = 1'b1;
    in_ctrl  = 8'hFF;
    in_data  = DW'(40);
    cyc();
    chk("bub.data", 128'(out_data), 128'(40));
    chk("bub.ctrl_live", 128'(out_ctrl), 128'(8'hFF));
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("bub%0d.valid", i), 128'(out_valid), 128'(0));
      chk($sformatf("bub%0d.ctrl", i), 128'(out_ctrl), 128'(0));
    end

    // Asynchronous reset mid-operation while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h77;
    in_data   = DW'(50);
    cyc();
    in_data = DW'(51);
    cyc();
    chk_st("rst_mid_pre", 1'b1, 1'b0, 2'd2);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_st("rst_mid", 1'b0, 1'b1, 2'd0);
    chk("rst_mid.ctrl", 128'(out_ctrl), 128'(0));
`ifdef PIPE_STAGE_DATA_RESET_EN
    chk("rst_mid.data", 128'(out_data), 128'(0));
`endif
    cyc();
    rst_n = 1'b1;
    cyc();
    chk_st("rst_mid_after", 1'b0, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
